regfile_wb_arbiter: RTL

Write-port arbiter and pending-write scoreboard for the single-write-port register file. Two writeback sources share the one `regwrite/wa/wd` port: the main pipeline (port A) and the multi-cycle unit (port B). Port A normally wins; a starvation counter guarantees B progress. A per-register pending mask tracks B-unit writes reserved at issue, and hazard flags on read addresses let the controller stall dependent reads.

---
 rtl/mips_pkg.sv | 7 +
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared register-file parameters used by the writeback arbiter and its scoreboard.
package mips_pkg;
  localparam int WIDTH    = 32;
  localparam int REGBITS  = 5;
  localparam int ZERO_REG = 0;
  localparam int STARVE   = 4;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write mask for multi-cycle (port B) results, reserved at issue and
// cleared when the B writeback is accepted; flags stale reads.
module wb_scoreboard
  import mips_pkg::*;
#(
  parameter int REGBITS = mips_pkg::REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rsv_valid,
  output logic               rsv_ready,
  input  logic [REGBITS-1:0] rsv_wa,
  input  logic               b_accept,
  input  logic [REGBITS-1:0] b_wa,
  input  logic               regwrite,
  input  logic [REGBITS-1:0] wa,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  output logic               hazard1,
  output logic               hazard2
);
  localparam int NREG = 1 << REGBITS;
  localparam logic [REGBITS-1:0] ZERO = REGBITS'(ZERO_REG);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  assign rsv_ready = rsv_valid & ((rsv_wa == ZERO) | ~pending[rsv_wa]);

  // Clear first, then set: a fresh reservation outlives a same-edge B retire.
  always_comb begin
    pending_next = pending;
    if (b_accept) pending_next[b_wa] = 1'b0;
    if (rsv_ready && (rsv_wa != ZERO)) pending_next[rsv_wa] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  // The in-flight output write is stale for one more cycle until the file commits it.
  assign hazard1 = (ra1 != ZERO) & (pending[ra1] | (regwrite & (wa == ra1)));
  assign hazard2 = (ra2 != ZERO) & (pending[ra2] | (regwrite & (wa == ra2)));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline (A) and
// the multi-cycle unit (B), with a starvation counter guaranteeing B progress.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH   = mips_pkg::WIDTH,
  parameter int REGBITS = mips_pkg::REGBITS,
  parameter int STARVE  = mips_pkg::STARVE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [REGBITS-1:0] a_wa,
  input  logic [WIDTH-1:0]   a_wd,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [REGBITS-1:0] b_wa,
  input  logic [WIDTH-1:0]   b_wd,
  input  logic               rsv_valid,
  output logic               rsv_ready,
  input  logic [REGBITS-1:0] rsv_wa,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  output logic               hazard1,
  output logic               hazard2,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);
  localparam logic [3:0]         STARVE_MAX = 4'(STARVE);
  localparam logic [REGBITS-1:0] ZERO       = REGBITS'(ZERO_REG);

  logic [3:0] starve_cnt;
  logic       force_b;

  // Handshake (A, B, reservation): a transfer happens at a rising edge where
  // valid & ready; valid holds with stable payload until accepted, and ready
  // is a combinational function of valid and current state.
  assign force_b = (starve_cnt == STARVE_MAX);
  assign b_ready = b_valid & (~a_valid | force_b);
  assign a_ready = a_valid & ~(force_b & b_valid);

  always_ff @(posedge clk) begin
    if (reset)                   starve_cnt <= '0;
    else if (~b_valid | b_ready) starve_cnt <= '0;
    else if (!force_b)           starve_cnt <= starve_cnt + 4'd1;
  end

  // Register-0 writes complete the handshake but never assert the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else if (a_ready) begin
      regwrite <= (a_wa != ZERO);
      wa       <= a_wa;
      wd       <= a_wd;
    end else if (b_ready) begin
      regwrite <= (b_wa != ZERO);
      wa       <= b_wa;
      wd       <= b_wd;
    end else begin
      regwrite <= 1'b0;
    end
  end

  wb_scoreboard #(.REGBITS(REGBITS)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (rsv_valid),
    .rsv_ready (rsv_ready),
    .rsv_wa    (rsv_wa),
    .b_accept  (b_ready),
    .b_wa      (b_wa),
    .regwrite  (regwrite),
    .wa        (wa),
    .ra1       (ra1),
    .ra2       (ra2),
    .hazard1   (hazard1),
    .hazard2   (hazard2)
  );
endmodule
